// File: rtl/uart_pkg.sv
// uart_pkg: UART state encoding and frame constants
// shared by the TX path and a future RX path
package uart_pkg;

  typedef enum logic [1:0] {
    UART_TX_IDLE,
    UART_TX_START,
    UART_TX_DATA,
    UART_TX_STOP
  } uart_tx_state_t;

  localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period counter; ports clock, reset_n, enable in,
// tick out (one cycle, last cycle of each bit period); count held 0 when idle
module uart_bit_timer #(
  parameter int CLOCKS_PER_BIT = 234
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int W = $clog2(CLOCKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLOCKS_PER_BIT - 1);

  logic [W-1:0] r_count;
  logic         w_last;

  assign w_last = (r_count == LAST);
  assign tick   = enable && w_last;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (!enable || w_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: valid/ready byte stream to 8N1 UART line
// in: clock, reset_n, valid, data[7:0]; out: ready, txd, busy (all registered)
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 234
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       valid,
  output logic       ready,
  input  logic [7:0] data,
  output logic       txd,
  output logic       busy
);

  localparam logic [2:0] LAST_IDX = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t r_state;
  logic [7:0]     r_shift;
  logic [2:0]     r_idx;
  logic           r_txd;
  logic           r_ready;
  logic           r_busy;
  logic           w_tick;
  logic           w_hs;
  logic           w_en;

  assign w_hs  = valid && r_ready;
  assign w_en  = (r_state != UART_TX_IDLE);
  assign ready = r_ready;
  assign txd   = r_txd;
  assign busy  = r_busy;

  uart_bit_timer #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .enable (w_en),
    .tick   (w_tick)
  );

  // txd is computed one edge ahead so the pin itself is a flop
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= UART_TX_IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_txd   <= 1'b1;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        UART_TX_IDLE: begin
          r_txd <= 1'b1;
          if (w_hs) begin
            r_state <= UART_TX_START;
            r_shift <= data;
            r_idx   <= '0;
            r_txd   <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end else begin
            r_ready <= 1'b1;
          end
        end
        UART_TX_START: begin
          if (w_tick) begin
            r_state <= UART_TX_DATA;
            r_txd   <= r_shift[0];
          end
        end
        UART_TX_DATA: begin
          if (w_tick) begin
            if (r_idx == LAST_IDX) begin
              r_state <= UART_TX_STOP;
              r_txd   <= 1'b1;
            end else begin
              r_shift <= r_shift >> 1;
              r_txd   <= r_shift[1];
              r_idx   <= r_idx + 1'b1;
            end
          end
        end
        UART_TX_STOP: begin
          if (w_tick) begin
            r_state <= UART_TX_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= UART_TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// tb_uart_tx_stream: scoreboard bench, three instances
// (bit periods 4, 2, 234) sharing clock and reset
module tb_uart_tx_stream;

  localparam int CPB0 = 4;
  localparam int CPB1 = 2;
  localparam int CPB2 = 234;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] valid_v;
  logic [2:0] ready_v;
  logic [2:0] busy_v;
  logic [2:0] txd_v;
  logic [7:0] data_v [3];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int viol = 0;
  int hs_cnt [3];
  int hs_q [$];
  logic [7:0] sbq [$];

  int n0;
  int n;

  always #5 clk = ~clk;

  uart_tx_stream #(.CLOCKS_PER_BIT(CPB0)) u_dut0 (
    .clock(clk), .reset_n(rst_n), .valid(valid_v[0]),
    .ready(ready_v[0]), .data(data_v[0]), .txd(txd_v[0]),
    .busy(busy_v[0])
  );

  uart_tx_stream #(.CLOCKS_PER_BIT(CPB1)) u_dut1 (
    .clock(clk), .reset_n(rst_n), .valid(valid_v[1]),
    .ready(ready_v[1]), .data(data_v[1]), .txd(txd_v[1]),
    .busy(busy_v[1])
  );

  uart_tx_stream #(.CLOCKS_PER_BIT(CPB2)) u_dut2 (
    .clock(clk), .reset_n(rst_n), .valid(valid_v[2]),
    .ready(ready_v[2]), .data(data_v[2]), .txd(txd_v[2]),
    .busy(busy_v[2])
  );

  // handshake log, and ready/busy exclusivity watch
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (valid_v[i] && ready_v[i]) begin
        hs_cnt[i] <= hs_cnt[i] + 1;
        if (i == 0) hs_q.push_back(cyc);
      end
      if (ready_v[i] && busy_v[i]) viol <= viol + 1;
    end
  end

  function automatic int cpb(input int i);
    return (i == 0) ? CPB0 : ((i == 1) ? CPB1 : CPB2);
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // call at a negedge; returns at a negedge
  task automatic send(input int i, input logic [7:0] b,
                      input bit push);
    int c0;
    int k;
    c0 = hs_cnt[i];
    k = 0;
    valid_v[i] = 1'b1;
    data_v[i] = b;
    if (push) sbq.push_back(b);
    while (hs_cnt[i] == c0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    valid_v[i] = 1'b0;
    if (hs_cnt[i] == c0)
      check($sformatf("send%0d_timeout", i), 1, 0);
  endtask

  // samples txd once per cycle on negedges from the start bit on
  task automatic decode(input int i);
    int c;
    int k;
    logic [9:0] bits;
    logic bad;
    logic [7:0] exp;
    c = cpb(i);
    k = 0;
    bits = '0;
    while (txd_v[i] !== 1'b0 && k < 20 * c + 100) begin
      @(negedge clk);
      k++;
    end
    if (txd_v[i] !== 1'b0) begin
      check($sformatf("dec%0d_timeout", i), 1, 0);
      return;
    end
    for (int b = 0; b < 10; b++) begin
      bad = 1'b0;
      for (int s = 0; s < c; s++) begin
        if (s == 0) bits[b] = txd_v[i];
        else if (txd_v[i] !== bits[b]) bad = 1'b1;
        if (b == 9 && s == c - 1) begin
          check($sformatf("dec%0d_rdy_end", i), ready_v[i], 0);
          check($sformatf("dec%0d_busy_end", i), busy_v[i], 1);
        end
        @(negedge clk);
      end
      check($sformatf("dec%0d_bit%0d_len", i, b), bad, 0);
    end
    check($sformatf("dec%0d_start", i), bits[0], 0);
    check($sformatf("dec%0d_stop", i), bits[9], 1);
    check($sformatf("dec%0d_rdy_rise", i), ready_v[i], 1);
    check($sformatf("dec%0d_busy_fall", i), busy_v[i], 0);
    if (sbq.size() == 0) begin
      check($sformatf("dec%0d_sb_empty", i), 1, 0);
    end else begin
      exp = sbq.pop_front();
      check($sformatf("dec%0d_byte", i), bits[8:1], exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    valid_v = '0;
    for (int i = 0; i < 3; i++) data_v[i] = '0;
    rst_n = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check("rst_txd", txd_v, 3'b111);
      check("rst_ready", ready_v, 3'b000);
      check("rst_busy", busy_v, 3'b000);
    end
    rst_n = 1'b1;
    #1;
    check("rel_ready_pre", ready_v, 3'b000);
    @(negedge clk);
    check("rel_ready_1edge", ready_v, 3'b111);
    check("rel_busy", busy_v, 3'b000);

    // single 0xA5
    fork
      send(0, 8'hA5, 1'b1);
      decode(0);
    join
    @(negedge clk);

    // continuous 0x00..0x05, valid held
    hs_q.delete();
    fork
      begin
        for (int b = 0; b < 6; b++) begin
          n0 = hs_cnt[0];
          n = 0;
          valid_v[0] = 1'b1;
          data_v[0] = 8'(b);
          sbq.push_back(8'(b));
          while (hs_cnt[0] == n0 && n < 200) begin
            @(negedge clk);
            n++;
          end
          if (hs_cnt[0] == n0) check("cont_hs_timeout", 1, 0);
        end
        valid_v[0] = 1'b0;
      end
      begin
        for (int j = 0; j < 6; j++) decode(0);
      end
    join
    check("cont_hs_count", hs_q.size(), 6);
    for (int j = 1; j < hs_q.size(); j++)
      check($sformatf("cont_gap%0d", j), hs_q[j] - hs_q[j-1], 41);
    @(negedge clk);

    // data/valid churn during a 0x3C frame
    n0 = hs_cnt[0];
    fork
      begin
        valid_v[0] = 1'b1;
        data_v[0] = 8'h3C;
        sbq.push_back(8'h3C);
        n = 0;
        while (hs_cnt[0] == n0 && n < 200) begin
          @(negedge clk);
          n++;
        end
        repeat (10 * CPB0 - 1) begin
          @(negedge clk);
          data_v[0] = 8'($urandom);
        end
        valid_v[0] = 1'b0;
      end
      decode(0);
    join
    check("stab_hs_count", hs_cnt[0] - n0, 1);
    @(negedge clk);

    // reset during data bit 3 of 0xFF
    send(0, 8'hFF, 1'b0);
    repeat (17) @(negedge clk);
    check("mid_busy_pre", busy_v[0], 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_txd_async", txd_v[0], 1);
    check("mid_busy_async", busy_v[0], 0);
    check("mid_ready_async", ready_v[0], 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_ready_rel", ready_v[0], 1);
    check("mid_txd_idle", txd_v[0], 1);
    fork
      send(0, 8'h00, 1'b1);
      decode(0);
    join
    @(negedge clk);

    // bit-period extremes
    for (int i = 1; i < 3; i++) begin
      fork
        send(i, 8'h00, 1'b1);
        decode(i);
      join
      @(negedge clk);
      fork
        send(i, 8'hFF, 1'b1);
        decode(i);
      join
      @(negedge clk);
    end

    check("ready_busy_excl", viol, 0);
    check("sb_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
